telemetry_poller: RTL and testbench

Initiator side of the command-byte protocol that the message interpreter answers. On a periodic tick it issues the fixed list of telemetry query codes to the interpreter, one at a time. For each code it captures the 8-bit reply from the interpreter's data-out bus. It then streams a framed packet of (code, value) pairs plus a checksum to the UART transmitter over a valid/ready handshake.

---
 rtl/telemetry_poller.sv | 180 ++++++++++++++++++
 tb/tb_telemetry_poller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_poller.sv
// Periodic telemetry poller: queries the message interpreter with a fixed code list,
// captures each reply and streams a framed (code, value) packet with XOR checksum to a UART.
`timescale 1ns/1ps
module telemetry_poller #(
  parameter int unsigned PERIOD_CYCLES = 5000000,
  parameter int unsigned PERIOD_WIDTH  = 23,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  SOF_BYTE      = 8'hAA
) (
  input  logic       TELEMETRY_POLLER_CLOCK_50,
  input  logic       TELEMETRY_POLLER_RESET_InHigh,
  input  logic       TELEMETRY_POLLER_ENABLE_InHigh,
  output logic [7:0] TELEMETRY_POLLER_CMD_OutBus,
  output logic       TELEMETRY_POLLER_FLAGCMD_Out,
  input  logic [7:0] TELEMETRY_POLLER_DATA_InBus,
  output logic [7:0] TELEMETRY_POLLER_TXDATA_OutBus,
  output logic       TELEMETRY_POLLER_TXVALID_OutHigh,
  input  logic       TELEMETRY_POLLER_TXREADY_InHigh,
  output logic       TELEMETRY_POLLER_BUSY_OutHigh,
  output logic       TELEMETRY_POLLER_FRAMEDONE_OutHigh
);

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned LAST_IDX = 14;
  localparam int unsigned SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, SEND_SOF, REQ, SEND_CODE, SEND_VAL, SEND_CSUM, DONE
  } state_e;

  logic clk, rst, en, ready;
  assign clk   = TELEMETRY_POLLER_CLOCK_50;
  assign rst   = TELEMETRY_POLLER_RESET_InHigh;
  assign en    = TELEMETRY_POLLER_ENABLE_InHigh;
  assign ready = TELEMETRY_POLLER_TXREADY_InHigh;

  state_e                  state_q;
  logic [PERIOD_WIDTH-1:0] per_q;
  logic                    pending_q;
  logic [IDX_W-1:0]        idx_q;
  logic [SET_W-1:0]        settle_q;
  logic [7:0]              val_q, csum_q, cmd_q, txd_q;
  logic                    flag_q, txv_q, busy_q, done_q;
  logic                    take_c;

  function automatic logic [7:0] query_code(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    return 8'd20;
      4'd1:    return 8'd21;
      4'd2:    return 8'd22;
      4'd3:    return 8'd30;
      4'd4:    return 8'd31;
      4'd5:    return 8'd32;
      4'd6:    return 8'd33;
      4'd7:    return 8'd40;
      4'd8:    return 8'd41;
      4'd9:    return 8'd42;
      4'd10:   return 8'd43;
      4'd11:   return 8'd50;
      4'd12:   return 8'd60;
      4'd13:   return 8'd61;
      4'd14:   return 8'd62;
      default: return 8'd0;
    endcase
  endfunction

  assign take_c = (state_q == IDLE) && pending_q;

  // Period counter; a wrap always wins over the FSM consuming the pending request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q     <= '0;
      pending_q <= 1'b0;
    end else if (!en) begin
      per_q     <= '0;
      pending_q <= 1'b0;
    end else if (per_q == PERIOD_WIDTH'(PERIOD_CYCLES - 1)) begin
      per_q     <= '0;
      pending_q <= 1'b1;
    end else begin
      per_q <= per_q + 1'b1;
      if (take_c) pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      val_q    <= 8'h00;
      csum_q   <= 8'h00;
      cmd_q    <= 8'h00;
      flag_q   <= 1'b0;
      txd_q    <= 8'h00;
      txv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            busy_q  <= 1'b1;
            idx_q   <= '0;
            csum_q  <= 8'h00;
            txd_q   <= SOF_BYTE;
            txv_q   <= 1'b1;
            state_q <= SEND_SOF;
          end
        end
        SEND_SOF: begin
          if (ready) begin
            txv_q    <= 1'b0;
            cmd_q    <= query_code(idx_q);
            flag_q   <= 1'b1;
            settle_q <= '0;
            state_q  <= REQ;
          end
        end
        REQ: begin
          flag_q <= 1'b0;
          // Reply is sampled on the edge closing the last settle cycle
          if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
            val_q   <= TELEMETRY_POLLER_DATA_InBus;
            cmd_q   <= 8'h00;
            txd_q   <= query_code(idx_q);
            txv_q   <= 1'b1;
            state_q <= SEND_CODE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        SEND_CODE: begin
          if (ready) begin
            csum_q  <= csum_q ^ txd_q;
            txd_q   <= val_q;
            state_q <= SEND_VAL;
          end
        end
        SEND_VAL: begin
          if (ready) begin
            csum_q <= csum_q ^ val_q;
            if (idx_q == IDX_W'(LAST_IDX)) begin
              txd_q   <= csum_q ^ val_q;
              state_q <= SEND_CSUM;
            end else begin
              idx_q    <= idx_q + 1'b1;
              txv_q    <= 1'b0;
              cmd_q    <= query_code(idx_q + 1'b1);
              flag_q   <= 1'b1;
              settle_q <= '0;
              state_q  <= REQ;
            end
          end
        end
        SEND_CSUM: begin
          if (ready) begin
            txv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TELEMETRY_POLLER_CMD_OutBus        = cmd_q;
  assign TELEMETRY_POLLER_FLAGCMD_Out       = flag_q;
  assign TELEMETRY_POLLER_TXDATA_OutBus     = txd_q;
  assign TELEMETRY_POLLER_TXVALID_OutHigh   = txv_q;
  assign TELEMETRY_POLLER_BUSY_OutHigh      = busy_q;
  assign TELEMETRY_POLLER_FRAMEDONE_OutHigh = done_q;

endmodule

// File: tb/tb_telemetry_poller.sv
// Bench for telemetry_poller: interpreter model, randomized TXREADY and a frame-level reference.
`timescale 1ns/1ps
module tb_telemetry_poller;

  localparam int unsigned PER = 200;
  localparam int unsigned SET = 2;

  logic       clk = 1'b0;
  logic       rst, en, flag, txv, txr, busy, fdone;
  logic [7:0] cmd, din, txd;

  telemetry_poller #(
    .PERIOD_CYCLES(PER), .PERIOD_WIDTH(8), .SETTLE_CYCLES(SET), .SOF_BYTE(8'hAA)
  ) dut (
    .TELEMETRY_POLLER_CLOCK_50         (clk),
    .TELEMETRY_POLLER_RESET_InHigh     (rst),
    .TELEMETRY_POLLER_ENABLE_InHigh    (en),
    .TELEMETRY_POLLER_CMD_OutBus       (cmd),
    .TELEMETRY_POLLER_FLAGCMD_Out      (flag),
    .TELEMETRY_POLLER_DATA_InBus       (din),
    .TELEMETRY_POLLER_TXDATA_OutBus    (txd),
    .TELEMETRY_POLLER_TXVALID_OutHigh  (txv),
    .TELEMETRY_POLLER_TXREADY_InHigh   (txr),
    .TELEMETRY_POLLER_BUSY_OutHigh     (busy),
    .TELEMETRY_POLLER_FRAMEDONE_OutHigh(fdone)
  );

  always #10 clk = ~clk;

  // Interpreter: valid reply one cycle after a code appears, junk on every other cycle
  always @(posedge clk) begin
    if (flag) din <= cmd ^ 8'h80;
    else      din <= 8'($urandom);
  end

  int checks = 0, failures = 0, cyc = 0, phase = 0;
  logic [7:0] got[$], exp_q[$];
  int flag_cnt, flag_bad, cmd_bad, hold_bad, busy_bad, fd_cnt, sof_cyc, done_cyc;
  int en_drop = -1, rst_at = -1;
  logic [7:0] bp_val;
  bit rst_hit;
  int codes[15] = '{20, 21, 22, 30, 31, 32, 33, 40, 41, 42, 43, 50, 60, 61, 62};

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Reference frame: SOF, (code, reply) pairs, XOR of all pair bytes
  function automatic int stream_errs();
    int e = 0;
    logic [7:0] cs = 8'h00;
    exp_q = {};
    exp_q.push_back(8'hAA);
    foreach (codes[i]) begin
      exp_q.push_back(8'(codes[i]));
      exp_q.push_back(8'(codes[i]) ^ 8'h80);
      cs = cs ^ 8'(codes[i]) ^ (8'(codes[i]) ^ 8'h80);
    end
    exp_q.push_back(cs);
    if (got.size() != exp_q.size()) return 100;
    foreach (got[i]) if (got[i] !== exp_q[i]) e++;
    return e;
  endfunction

  // mode 0: ready high; 1: stall byte bp_idx for bp_len cycles; 2: random ready;
  // 3: stall byte bp_idx at least bp_len cycles and until wrap phase + 10
  task automatic collect_frame(input int mode, input int bp_idx, input int bp_len, input int wait_max);
    int stall = 0;
    bit r = 1'b1;
    bit seen = 1'b0;
    logic [7:0] p_cmd = 8'h00, p_txd = 8'h00;
    bit p_v = 1'b0, p_r = 1'b0;
    got = {}; flag_cnt = 0; flag_bad = 0; cmd_bad = 0; hold_bad = 0; busy_bad = 0;
    fd_cnt = 0; rst_hit = 1'b0; bp_val = 8'h00;
    for (int i = 0; i < wait_max && !busy; i++) step();
    if (!busy) begin
      checks++; failures++;
      $display("FAIL frame_start: BUSY=%b after %0d cycles, required 1", busy, wait_max);
      return;
    end
    sof_cyc = cyc;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (i != 0) step();
      if (cmd >= 8'd1 && cmd <= 8'd10) cmd_bad++;
      if (txv && cmd != 8'h00) cmd_bad++;
      if (flag) begin
        flag_cnt++;
        if (cmd == 8'h00 || p_cmd != 8'h00) flag_bad++;
      end else if (cmd != 8'h00 && p_cmd == 8'h00) flag_bad++;
      if (p_v && !p_r && (!txv || txd !== p_txd)) hold_bad++;
      if (fdone) begin
        fd_cnt++; done_cyc = cyc; seen = 1'b1;
        if (busy || txv) busy_bad++;
      end else if (!busy) busy_bad++;
      if (rst_at >= 0 && got.size() == rst_at && txv) begin
        rst_hit = 1'b1;
        return;
      end
      if (en_drop >= 0 && got.size() == en_drop) en = 1'b0;
      case (mode)
        1: r = !(txv && got.size() == bp_idx && stall < bp_len);
        2: r = ($urandom_range(3) != 0);
        3: r = !(txv && got.size() == bp_idx &&
                 (stall < bp_len || ((cyc + PER - phase) % PER) != 10));
        default: r = 1'b1;
      endcase
      if (!r && stall == 0) bp_val = txd;
      if (!r) stall++;
      txr = r;
      if (txv && r) got.push_back(txd);
      p_cmd = cmd; p_txd = txd; p_v = txv; p_r = r;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL frame_done: FRAMEDONE not seen within 3000 cycles, got %0d bytes", got.size());
      return;
    end
    step();
    if (fdone) fd_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (cmd !== 8'h00)  begin failures++; $display("FAIL rst_cmd: got %h, required 00", cmd); end
    checks++; if (flag !== 1'b0)  begin failures++; $display("FAIL rst_flag: got %b, required 0", flag); end
    checks++; if (txd !== 8'h00)  begin failures++; $display("FAIL rst_txdata: got %h, required 00", txd); end
    checks++; if (txv !== 1'b0)   begin failures++; $display("FAIL rst_txvalid: got %b, required 0", txv); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (fdone !== 1'b0) begin failures++; $display("FAIL rst_framedone: got %b, required 0", fdone); end
    rst = 1'b0; en = 1'b1; txr = 1'b1;
  endtask

  task automatic test_nominal();
    int first, e;
    collect_frame(0, 0, 0, PER + 20);
    e = stream_errs();
    checks++; if (e != 0) begin failures++; $display("FAIL nom_stream: %0d bad bytes (len %0d), required 0 (len 32)", e, got.size()); end
    checks++; if (got.size() == 32 && got[31] !== 8'h80) begin failures++; $display("FAIL nom_csum: got %h, required 80", got[31]); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL nom_framedone: %0d pulse cycles, required 1", fd_cnt); end
    checks++; if (flag_cnt != 15 || flag_bad != 0) begin failures++; $display("FAIL nom_flagcmd: count %0d bad %0d, required 15 and 0", flag_cnt, flag_bad); end
    checks++; if (cmd_bad != 0) begin failures++; $display("FAIL nom_cmd: %0d bad cycles, required 0", cmd_bad); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL nom_busy: %0d bad cycles, required 0", busy_bad); end
    checks++; if (done_cyc - sof_cyc + 1 != 63) begin failures++; $display("FAIL nom_time: SOF..DONE %0d cycles, required 63", done_cyc - sof_cyc + 1); end
    phase = sof_cyc % PER;
    first = sof_cyc;
    collect_frame(0, 0, 0, PER + 20);
    checks++; if (sof_cyc - first != PER) begin failures++; $display("FAIL nom_period: %0d cycles between frames, required %0d", sof_cyc - first, PER); end
  endtask

  task automatic test_backpressure();
    int e;
    collect_frame(1, 2, 5, PER + 20);
    e = stream_errs();
    checks++; if (e != 0) begin failures++; $display("FAIL bp_stream: %0d bad bytes (len %0d), required 0", e, got.size()); end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL bp_hold: %0d unstable cycles, required 0", hold_bad); end
    checks++; if (bp_val !== 8'h94) begin failures++; $display("FAIL bp_byte: stalled on %h, required 94", bp_val); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL bp_framedone: %0d pulse cycles, required 1", fd_cnt); end
  endtask

  task automatic test_random_ready();
    int e;
    for (int f = 0; f < 3; f++) begin
      collect_frame(2, 0, 0, 2 * PER);
      e = stream_errs();
      checks++; if (e != 0) begin failures++; $display("FAIL rnd_stream%0d: %0d bad bytes (len %0d), required 0", f, e, got.size()); end
      checks++; if (hold_bad + flag_bad + cmd_bad + busy_bad != 0) begin failures++; $display("FAIL rnd_proto%0d: hold %0d flag %0d cmd %0d busy %0d, required all 0", f, hold_bad, flag_bad, cmd_bad, busy_bad); end
    end
  endtask

  task automatic test_overrun();
    int t, e, act;
    collect_frame(3, 2, 500, 2 * PER);
    e = stream_errs();
    checks++; if (e != 0) begin failures++; $display("FAIL ovr_stream_a: %0d bad bytes, required 0", e); end
    t = done_cyc;
    collect_frame(0, 0, 0, 10);
    checks++; if (sof_cyc != t + 2) begin failures++; $display("FAIL ovr_restart: SOF at DONE+%0d, required DONE+2", sof_cyc - t); end
    e = stream_errs();
    checks++; if (e != 0) begin failures++; $display("FAIL ovr_stream_b: %0d bad bytes, required 0", e); end
    en_drop = 4;
    collect_frame(0, 0, 0, 2 * PER);
    en_drop = -1;
    checks++; if (sof_cyc % PER != phase) begin failures++; $display("FAIL ovr_collapse: next SOF phase %0d, required %0d", sof_cyc % PER, phase); end
    e = stream_errs();
    checks++; if (e != 0 || fd_cnt != 1) begin failures++; $display("FAIL en_off_finish: %0d bad bytes, %0d done pulses, required 0 and 1", e, fd_cnt); end
    act = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      step();
      if (busy || txv || cmd != 8'h00) act++;
    end
    checks++; if (act != 0) begin failures++; $display("FAIL en_off_quiet: %0d active cycles, required 0", act); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int act, e;
    rst_at = 9;
    collect_frame(0, 0, 0, 2 * PER);
    rst_at = -1;
    checks++; if (!rst_hit) begin failures++; $display("FAIL mid_reach: byte 10 not reached, got %0d bytes", got.size()); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({cmd, flag, txd, txv, busy, fdone} !== 20'h0) begin
      failures++; $display("FAIL mid_async: cmd %h flag %b txd %h txv %b busy %b done %b, required all 0", cmd, flag, txd, txv, busy, fdone);
    end
    step(); step();
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 190; i++) begin
      step();
      if (busy || txv || flag || cmd != 8'h00) act++;
    end
    checks++; if (act != 0) begin failures++; $display("FAIL mid_quiet: %0d active cycles, required 0", act); end
    collect_frame(0, 0, 0, PER);
    e = stream_errs();
    checks++; if (got.size() == 0 || got[0] !== 8'hAA || e != 0) begin failures++; $display("FAIL mid_clean: %0d bad bytes (len %0d), required 0 starting AA", e, got.size()); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; txr = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_random_ready();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
